// File: rtl/risc_mem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : risc_mem_pkg                                             |
// | Description : Shared op, fault and state encodings for the memory unit |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package risc_mem_pkg;

    typedef enum logic [2:0] {
        OP_FETCH = 3'd0,
        OP_LOAD  = 3'd1,
        OP_STORE = 3'd2,
        OP_PUSH  = 3'd3,
        OP_POP   = 3'd4
    } mem_op_e;

    typedef enum logic [1:0] {
        FLT_NONE       = 2'd0,
        FLT_ILLEGAL_OP = 2'd1,
        FLT_STACK      = 2'd2,
        FLT_TIMEOUT    = 2'd3
    } mem_fault_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RESPOND = 2'd2,
        S_FAULT   = 2'd3
    } mem_state_e;

    function automatic logic is_legal_op(input logic [2:0] i_op);
        return i_op <= 3'd4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/risc_mem_timeout.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : risc_mem_timeout                                         |
// | Description : Bus wait counter; flags the wait that reaches TIMEOUT    |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module risc_mem_timeout #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam int              c_CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
            localparam logic [c_CW-1:0] c_MAX  = c_CW'(TIMEOUT);
            localparam logic [c_CW-1:0] c_LAST = c_CW'(TIMEOUT - 1);
            localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

            logic [c_CW-1:0] r_count;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_count <= '0;
                end else if (i_clear) begin
                    r_count <= '0;
                end else if (i_enable && (r_count != c_MAX)) begin
                    r_count <= r_count + c_ONE;
                end
            end

            // Expires on the wait cycle whose increment brings the count to TIMEOUT
            assign o_expired = i_enable && (r_count == c_LAST);
        end else begin : g_no_timeout
            logic w_unused;
            assign w_unused  = &{1'b0, clk, rst_n, i_clear, i_enable};
            assign o_expired = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/risc_mem_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : risc_mem_unit                                            |
// | Description : Memory-access sequencer: fetch/load/store/push/pop with  |
// |               wait states, bounded stack and bus timeout               |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module risc_mem_unit
    import risc_mem_pkg::*;
#(
    parameter int          DATA_WIDTH  = 16,
    parameter int          ADDR_WIDTH  = 16,
    parameter int unsigned STACK_BASE  = 'h0200,
    parameter int unsigned STACK_LIMIT = 'h0300,
    parameter int          TIMEOUT     = 15
) (
    input  logic                  aClock,
    input  logic                  aResetN,
    input  logic                  aRequest,
    input  logic [2:0]            anOp,
    input  logic [ADDR_WIDTH-1:0] anAddress,
    input  logic [DATA_WIDTH-1:0] aWriteData,
    input  logic                  aClearFault,
    output logic                  anOutBusy,
    output logic                  anOutDone,
    output logic [DATA_WIDTH-1:0] anOutReadData,
    output logic [ADDR_WIDTH-1:0] anOutStackPointer,
    output logic                  anOutFault,
    output logic [1:0]            anOutFaultCode,
    output logic                  anOutMemRequest,
    output logic [ADDR_WIDTH-1:0] anOutMemAddress,
    output logic [DATA_WIDTH-1:0] anOutMemData,
    output logic                  anOutMemWrite,
    input  logic                  aMemReady,
    input  logic [DATA_WIDTH-1:0] aMemData
);

    localparam logic [ADDR_WIDTH-1:0] c_STACK_BASE  = ADDR_WIDTH'(STACK_BASE);
    localparam logic [ADDR_WIDTH-1:0] c_STACK_LIMIT = ADDR_WIDTH'(STACK_LIMIT);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE    = ADDR_WIDTH'(1);

    mem_state_e            r_state;
    mem_state_e            w_state_nxt;
    mem_fault_e            r_fault_code;
    mem_fault_e            w_check_code;
    logic [2:0]            r_op;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_sp;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] w_bus_addr;
    logic                  w_access;
    logic                  w_wait_clear;
    logic                  w_wait_enable;
    logic                  w_expired;

    assign w_access      = (r_state == S_ACCESS);
    assign w_wait_clear  = !w_access;
    assign w_wait_enable = w_access && !aMemReady;

    risc_mem_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (aClock),
        .rst_n     (aResetN),
        .i_clear   (w_wait_clear),
        .i_enable  (w_wait_enable),
        .o_expired (w_expired)
    );

    // Request checks in priority order; the first failure wins
    always_comb begin
        w_check_code = FLT_NONE;
        if (!is_legal_op(anOp)) begin
            w_check_code = FLT_ILLEGAL_OP;
        end else if ((anOp == OP_PUSH) && (r_sp == c_STACK_LIMIT)) begin
            w_check_code = FLT_STACK;
        end else if ((anOp == OP_POP) && (r_sp == c_STACK_BASE)) begin
            w_check_code = FLT_STACK;
        end
    end

    always_comb begin
        w_bus_addr = anAddress;
        if (anOp == OP_PUSH) begin
            w_bus_addr = r_sp;
        end else if (anOp == OP_POP) begin
            w_bus_addr = r_sp - c_ADDR_ONE;
        end
    end

    always_ff @(posedge aClock or negedge aResetN) begin
        if (!aResetN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (aRequest) begin
                    w_state_nxt = (w_check_code == FLT_NONE) ? S_ACCESS : S_FAULT;
                end
            end
            S_ACCESS: begin
                if (aMemReady) begin
                    w_state_nxt = S_RESPOND;
                end else if (w_expired) begin
                    w_state_nxt = S_FAULT;
                end
            end
            S_RESPOND: w_state_nxt = S_IDLE;
            S_FAULT: begin
                if (aClearFault) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aClock or negedge aResetN) begin
        if (!aResetN) begin
            r_op         <= 3'd0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_write      <= 1'b0;
            r_rdata      <= '0;
            r_sp         <= c_STACK_BASE;
            r_fault_code <= FLT_NONE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (aRequest) begin
                        r_op    <= anOp;
                        r_addr  <= w_bus_addr;
                        r_wdata <= aWriteData;
                        r_write <= (anOp == OP_STORE) || (anOp == OP_PUSH);
                        r_fault_code <= w_check_code;
                    end
                end
                S_ACCESS: begin
                    // SP moves on the ready edge so it is already updated while done is high
                    if (aMemReady) begin
                        if (!r_write) begin
                            r_rdata <= aMemData;
                        end
                        if (r_op == OP_PUSH) begin
                            r_sp <= r_sp + c_ADDR_ONE;
                        end else if (r_op == OP_POP) begin
                            r_sp <= r_sp - c_ADDR_ONE;
                        end
                    end else if (w_expired) begin
                        r_fault_code <= FLT_TIMEOUT;
                    end
                end
                S_FAULT: begin
                    if (aClearFault) begin
                        r_fault_code <= FLT_NONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign anOutBusy         = (r_state != S_IDLE);
    assign anOutDone         = (r_state == S_RESPOND);
    assign anOutFault        = (r_state == S_FAULT);
    assign anOutFaultCode    = r_fault_code;
    assign anOutReadData     = r_rdata;
    assign anOutStackPointer = r_sp;
    assign anOutMemRequest   = w_access;
    assign anOutMemAddress   = w_access ? r_addr  : '0;
    assign anOutMemData      = w_access ? r_wdata : '0;
    assign anOutMemWrite     = w_access && r_write;

endmodule
`default_nettype wire

// File: tb/tb_risc_mem_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_risc_mem_unit                                         |
// | Description : Scoreboard bench with memory responder and ref model     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_risc_mem_unit;

    localparam int BASE  = 'h0200;
    localparam int LIMIT = 'h0300;
    localparam int TMO   = 15;

    logic        aClock = 1'b0;
    logic        aResetN;
    logic        aRequest;
    logic [2:0]  anOp;
    logic [15:0] anAddress;
    logic [15:0] aWriteData;
    logic        aClearFault;
    logic        anOutBusy;
    logic        anOutDone;
    logic [15:0] anOutReadData;
    logic [15:0] anOutStackPointer;
    logic        anOutFault;
    logic [1:0]  anOutFaultCode;
    logic        anOutMemRequest;
    logic [15:0] anOutMemAddress;
    logic [15:0] anOutMemData;
    logic        anOutMemWrite;
    logic        aMemReady;
    logic [15:0] aMemData;

    risc_mem_unit #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (16),
        .STACK_BASE (BASE),
        .STACK_LIMIT(LIMIT),
        .TIMEOUT    (TMO)
    ) dut (
        .aClock            (aClock),
        .aResetN           (aResetN),
        .aRequest          (aRequest),
        .anOp              (anOp),
        .anAddress         (anAddress),
        .aWriteData        (aWriteData),
        .aClearFault       (aClearFault),
        .anOutBusy         (anOutBusy),
        .anOutDone         (anOutDone),
        .anOutReadData     (anOutReadData),
        .anOutStackPointer (anOutStackPointer),
        .anOutFault        (anOutFault),
        .anOutFaultCode    (anOutFaultCode),
        .anOutMemRequest   (anOutMemRequest),
        .anOutMemAddress   (anOutMemAddress),
        .anOutMemData      (anOutMemData),
        .anOutMemWrite     (anOutMemWrite),
        .aMemReady         (aMemReady),
        .aMemData          (aMemData)
    );

    always #5 aClock = ~aClock;

    typedef struct {
        bit          is_fault;
        logic [1:0]  code;
        logic [15:0] rdata;
        logic [15:0] sp;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] ref_mem[int];
    logic [15:0] bus_mem[int];
    int          ref_sp   = BASE;
    logic [15:0] ref_rdata = '0;
    int          resp_wait = 0;

    // Unwritten locations return a fixed address-derived pattern in both memories
    function automatic logic [15:0] init_word(input int a);
        return 16'(a) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] ref_read(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Memory responder: ready after resp_wait low cycles of a request
    initial begin : responder
        bit in_req;
        int wait_left;
        in_req    = 0;
        wait_left = 0;
        aMemReady = 1'b0;
        aMemData  = '0;
        forever begin
            @(negedge aClock);
            aMemReady = 1'b0;
            aMemData  = 16'($urandom);
            if (aResetN && anOutMemRequest) begin
                if (!in_req) begin
                    in_req    = 1;
                    wait_left = resp_wait;
                end
                if (wait_left == 0) begin
                    aMemReady = 1'b1;
                    if (anOutMemWrite) begin
                        bus_mem[int'(anOutMemAddress)] = anOutMemData;
                    end else begin
                        aMemData = bus_mem.exists(int'(anOutMemAddress)) ?
                                   bus_mem[int'(anOutMemAddress)] : init_word(int'(anOutMemAddress));
                    end
                end else begin
                    wait_left--;
                end
            end else begin
                in_req = 0;
            end
        end
    end

    // Monitor: pops an expectation on every done pulse and every fault entry
    initial begin : monitor
        bit   prev_fault;
        exp_t e;
        prev_fault = 0;
        forever begin
            @(negedge aClock);
            if (!aResetN) begin
                prev_fault = 0;
                continue;
            end
            if (anOutDone || (anOutFault && !prev_fault)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: done=%0b fault=%0b with empty scoreboard at %0t",
                             anOutDone, anOutFault, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind_fault", anOutFault, e.is_fault);
                    check("fault_code", anOutFaultCode, e.code);
                    check("stack_pointer", anOutStackPointer, e.sp);
                    check("read_data", anOutReadData, e.rdata);
                end
            end
            prev_fault = anOutFault;
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 50 && anOutBusy; i++) @(negedge aClock);
    endtask

    // Issue one access from a negedge; w = low-ready cycles the memory inserts
    task automatic issue(input logic [2:0] op, input logic [15:0] addr,
                         input logic [15:0] data, input int w);
        exp_t        e;
        bit          pre_fault;
        bit          tmo;
        bit          seen;
        bit          is_wr;
        int          cyc;
        int          nreq;
        int          exp_lat;
        logic [15:0] exp_baddr;

        wait_idle();
        pre_fault = 0;
        tmo       = (w >= TMO);
        is_wr     = (op == 3'd2) || (op == 3'd3);
        exp_baddr = addr;
        e.code    = 2'd0;
        if (op > 3'd4) begin
            pre_fault = 1;
            e.code    = 2'd1;
        end else if (op == 3'd3 && ref_sp == LIMIT) begin
            pre_fault = 1;
            e.code    = 2'd2;
        end else if (op == 3'd4 && ref_sp == BASE) begin
            pre_fault = 1;
            e.code    = 2'd2;
        end else begin
            if (op == 3'd3) exp_baddr = 16'(ref_sp);
            if (op == 3'd4) exp_baddr = 16'(ref_sp - 1);
            if (tmo) begin
                e.code = 2'd3;
            end else begin
                case (op)
                    3'd0, 3'd1: ref_rdata = ref_read(int'(addr));
                    3'd2:       ref_mem[int'(addr)] = data;
                    3'd3: begin
                        ref_mem[ref_sp] = data;
                        ref_sp++;
                    end
                    default: begin
                        ref_sp--;
                        ref_rdata = ref_read(ref_sp);
                    end
                endcase
            end
        end
        e.is_fault = pre_fault || tmo;
        e.sp       = 16'(ref_sp);
        e.rdata    = ref_rdata;
        exp_q.push_back(e);

        nreq    = pre_fault ? 0 : (tmo ? TMO : w + 1);
        exp_lat = pre_fault ? 1 : (tmo ? TMO + 1 : w + 2);
        resp_wait = tmo ? 1000 : w;
        aRequest   = 1'b1;
        anOp       = op;
        anAddress  = addr;
        aWriteData = data;
        cyc  = 0;
        seen = 0;
        while (cyc < 60 && !seen) begin
            @(negedge aClock);
            cyc++;
            if (cyc <= nreq) begin
                check("bus_request", anOutMemRequest, 1'b1);
                check("bus_address", anOutMemAddress, exp_baddr);
                check("bus_write", anOutMemWrite, is_wr);
                if (is_wr) check("bus_wdata", anOutMemData, data);
            end else if (cyc == nreq + 1) begin
                check("bus_request_dropped", anOutMemRequest, 1'b0);
            end
            // Requests while busy must be ignored
            if (anOutBusy) begin
                aRequest  = 1'($urandom_range(0, 1));
                anOp      = 3'($urandom);
                anAddress = 16'($urandom);
            end else begin
                aRequest = 1'b0;
            end
            seen = e.is_fault ? anOutFault : anOutDone;
        end
        aRequest = 1'b0;
        check("latency", cyc, exp_lat);
        if (!seen) exp_q.delete();

        if (e.is_fault || anOutFault) begin
            repeat (2) @(negedge aClock);
            check("fault_held", anOutFault, 1'b1);
            check("fault_bus_idle", anOutMemRequest, 1'b0);
            aClearFault = 1'b1;
            @(negedge aClock);
            aClearFault = 1'b0;
            check("fault_cleared", anOutFault, 1'b0);
            check("code_cleared", anOutFaultCode, 2'd0);
            check("sp_after_clear", anOutStackPointer, 16'(ref_sp));
        end else begin
            @(negedge aClock);
            check("idle_after_done", anOutBusy, 1'b0);
        end
    endtask

    initial begin : driver
        int r;
        aResetN     = 1'b0;
        aRequest    = 1'b0;
        anOp        = 3'd0;
        anAddress   = '0;
        aWriteData  = '0;
        aClearFault = 1'b0;
        repeat (2) @(negedge aClock);
        check("rst_busy", anOutBusy, 1'b0);
        check("rst_done", anOutDone, 1'b0);
        check("rst_sp", anOutStackPointer, 16'(BASE));
        check("rst_fault", anOutFault, 1'b0);
        check("rst_code", anOutFaultCode, 2'd0);
        check("rst_memreq", anOutMemRequest, 1'b0);
        check("rst_rdata", anOutReadData, 16'd0);
        check("rst_write", anOutMemWrite, 1'b0);
        aResetN = 1'b1;
        @(negedge aClock);

        bus_mem['h0400] = 16'hBEEF;
        ref_mem['h0400] = 16'hBEEF;
        issue(3'd1, 16'h0400, 16'h0000, 0);
        issue(3'd2, 16'h0010, 16'h1234, 3);
        issue(3'd3, 16'h0000, 16'hAAAA, 1);
        issue(3'd4, 16'h0000, 16'h0000, 0);
        issue(3'd4, 16'h0000, 16'h0000, 0);
        issue(3'd1, 16'h0010, 16'h0000, 2);

        for (int i = 0; i < LIMIT - BASE; i++)
            issue(3'd3, 16'($urandom), 16'($urandom), $urandom_range(0, 2));
        issue(3'd3, 16'h0000, 16'h5555, 0);
        for (int i = 0; i < 8; i++)
            issue(3'd4, 16'($urandom), 16'h0000, $urandom_range(0, 2));

        issue(3'd1, 16'h0055, 16'h0000, TMO);
        issue(3'd1, 16'h0056, 16'h0000, TMO - 1);
        issue(3'd7, 16'h0123, 16'h4567, 0);

        // Reset in the middle of an access
        resp_wait = 10;
        aRequest  = 1'b1;
        anOp      = 3'd1;
        anAddress = 16'h0077;
        @(negedge aClock);
        aRequest = 1'b0;
        @(negedge aClock);
        check("mid_access_req", anOutMemRequest, 1'b1);
        #2 aResetN = 1'b0;
        #1;
        check("async_rst_busy", anOutBusy, 1'b0);
        check("async_rst_req", anOutMemRequest, 1'b0);
        check("async_rst_done", anOutDone, 1'b0);
        check("async_rst_sp", anOutStackPointer, 16'(BASE));
        check("async_rst_addr", anOutMemAddress, 16'd0);
        exp_q.delete();
        ref_sp    = BASE;
        ref_rdata = '0;
        @(negedge aClock);
        aResetN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aClock);
            check("no_done_after_rst", anOutDone, 1'b0);
        end

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            issue((r < 6) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)),
                  16'($urandom_range(0, 'h3FF)), 16'($urandom),
                  (r > 95) ? $urandom_range(TMO - 1, TMO + 2) : $urandom_range(0, 3));
        end

        @(negedge aClock);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
